// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and constants for the memory sequencing controller.
// Holds the sequencer state encoding, word/alignment constants, the default
// reset fetch address and a small alignment helper.
package mem_seq_pkg;

  // Sequencer phase: SYNC waits for the memory's fetch phase, then the
  // controller alternates FETCH/EXEC in lock-step with the memory's E flag.
  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } seq_state_e;

  localparam int unsigned WORD_BYTES       = 32'd4;
  localparam logic [1:0]  ALIGN_MASK       = 2'b11;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // True when the low address bits select a non-word-aligned byte.
  function automatic logic is_misaligned(input logic [1:0] lsb_i);
    return (lsb_i & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_seq_pc.sv
// mem_seq_pc: program counter for mem_seq_ctrl.
// Owns the pc register, the branch redirect mux (targets are forced to a word
// boundary), the +4 sequential incrementer and the redirect alignment check.
// The pc only advances when the controller commits a fetch.
module mem_seq_pc
  import mem_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              commit_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] fa_o,
  output logic              br_misalign_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] fa_s;
  logic              br_mis_s;

  // Fetch address: word-aligned redirect target when branching, else pc.
  always_comb begin
    fa_s     = pc_q;
    br_mis_s = 1'b0;
    if (br_valid_i) begin
      fa_s     = {br_target_i[ADDR_W-1:2], 2'b00};
      br_mis_s = is_misaligned(br_target_i[1:0]);
    end else begin
      fa_s     = pc_q;
      br_mis_s = 1'b0;
    end
  end

  // Next pc: the word after the committed fetch address; wraps naturally.
  always_comb begin
    pc_d = pc_q;
    if (commit_i) begin
      pc_d = fa_s + ADDR_W'(WORD_BYTES);
    end else begin
      pc_d = pc_q;
    end
  end

  // pc register with asynchronous reset to the boot address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o          = pc_q;
  assign fa_o          = fa_s;
  assign br_misalign_o = br_mis_s;

endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: processor-side initiator for the main memory's alternating
// fetch/execute protocol. Tracks the memory phase flag, drives next-PC, data
// address, write data and store strobe, and returns the fetched instruction
// and load data to the core as single-cycle valid pulses.
// Optional feature macro: SEQ_RETIRE_CNT_EN adds a 32-bit retire_cnt output
// counting delivered instructions.
module mem_seq_ctrl
  import mem_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              ls_valid,
  input  logic              ls_store,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              align_err,
  output logic [ADDR_W-1:0] mem_next_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_s,
  input  logic              mem_e,
  input  logic [DATA_W-1:0] mem_mout
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  seq_state_e        state_q;
  seq_state_e        state_d;

  logic [ADDR_W-1:0] pc_s;
  logic [ADDR_W-1:0] fa_s;
  logic              br_mis_s;

  logic              fetch_ok_s;
  logic              exec_ok_s;
  logic              ls_mis_s;
  logic              accept_s;
  logic              accept_load_s;

  logic [ADDR_W-1:0] last_fa_q,     last_fa_d;
  logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;
  logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
  logic [DATA_W-1:0] instr_q,       instr_d;
  logic [DATA_W-1:0] ld_data_q,     ld_data_d;
  logic              instr_valid_q, instr_valid_d;
  logic              ld_valid_q,    ld_valid_d;
  logic              ld_pend_q,     ld_pend_d;
  logic              align_err_q,   align_err_d;

  mem_seq_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i         (clk),
    .rst_i         (Reset),
    .br_valid_i    (br_valid),
    .br_target_i   (br_target),
    .commit_i      (fetch_ok_s),
    .pc_o          (pc_s),
    .fa_o          (fa_s),
    .br_misalign_o (br_mis_s)
  );

  // Phase qualifiers: a state only does work when the memory agrees on the phase.
  always_comb begin
    fetch_ok_s    = (state_q == FETCH) && (mem_e == 1'b0);
    exec_ok_s     = (state_q == EXEC) && (mem_e == 1'b1);
    ls_mis_s      = is_misaligned(ls_addr[1:0]);
    accept_s      = exec_ok_s && ls_valid;
    accept_load_s = accept_s && !ls_store && !ls_mis_s;
  end

  // Next-state logic: lock-step FETCH/EXEC, fall back to SYNC on phase loss.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC: begin
        if (mem_e == 1'b0) begin
          state_d = FETCH;
        end else begin
          state_d = SYNC;
        end
      end
      FETCH: begin
        if (mem_e == 1'b1) begin
          state_d = SYNC;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (mem_e == 1'b0) begin
          state_d = SYNC;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Memory-side and handshake outputs; the strobe is only raised for an
  // aligned store accepted in a valid execute phase.
  always_comb begin
    mem_next_pc = pc_s;
    ls_ready    = 1'b0;
    mem_s       = 1'b0;
    mem_addr    = mem_addr_q;
    mem_wdata   = mem_wdata_q;
    case (state_q)
      SYNC:  mem_next_pc = pc_s;
      FETCH: mem_next_pc = fa_s;
      EXEC: begin
        mem_next_pc = last_fa_q;
        ls_ready    = exec_ok_s;
        if (accept_s) begin
          mem_addr  = ls_addr;
          mem_wdata = ls_wdata;
          mem_s     = ls_store && !ls_mis_s;
        end else begin
          mem_addr  = mem_addr_q;
          mem_wdata = mem_wdata_q;
          mem_s     = 1'b0;
        end
      end
      default: mem_next_pc = pc_s;
    endcase
  end

  // Capture and pulse logic: instruction at the execute edge, load data at
  // the following fetch edge, alignment errors one cycle after the event.
  always_comb begin
    last_fa_d     = last_fa_q;
    instr_pc_d    = instr_pc_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    instr_d       = instr_q;
    ld_data_d     = ld_data_q;
    instr_valid_d = exec_ok_s;
    ld_pend_d     = accept_load_s;
    ld_valid_d    = fetch_ok_s && ld_pend_q;
    align_err_d   = (fetch_ok_s && br_mis_s) || (accept_s && ls_mis_s);

    if (fetch_ok_s) begin
      last_fa_d  = fa_s;
      instr_pc_d = fa_s;
    end else begin
      last_fa_d  = last_fa_q;
      instr_pc_d = instr_pc_q;
    end

    if (exec_ok_s) begin
      instr_d = mem_mout;
    end else begin
      instr_d = instr_q;
    end

    if (accept_s) begin
      mem_addr_d  = ls_addr;
      mem_wdata_d = ls_wdata;
    end else begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
    end

    if (fetch_ok_s && ld_pend_q) begin
      ld_data_d = mem_mout;
    end else begin
      ld_data_d = ld_data_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset drops any in-flight load or fetch.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      last_fa_q     <= RESET_PC;
      instr_pc_q    <= {ADDR_W{1'b0}};
      mem_addr_q    <= {ADDR_W{1'b0}};
      mem_wdata_q   <= {DATA_W{1'b0}};
      instr_q       <= {DATA_W{1'b0}};
      ld_data_q     <= {DATA_W{1'b0}};
      instr_valid_q <= 1'b0;
      ld_valid_q    <= 1'b0;
      ld_pend_q     <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      last_fa_q     <= last_fa_d;
      instr_pc_q    <= instr_pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      instr_q       <= instr_d;
      ld_data_q     <= ld_data_d;
      instr_valid_q <= instr_valid_d;
      ld_valid_q    <= ld_valid_d;
      ld_pend_q     <= ld_pend_d;
      align_err_q   <= align_err_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign ld_valid    = ld_valid_q;
  assign ld_data     = ld_data_q;
  assign align_err   = align_err_q;

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;
  logic [31:0] retire_cnt_d;

  // Retired-instruction count: one per delivered instruction, wraps at 2^32.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (instr_valid_q) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      retire_cnt_q <= 32'd0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
